// File: rtl/bram_stream_reader.sv
// bram_stream_reader: reads a burst of words from a block RAM with one cycle
// of read latency and presents them on a valid/ready stream through a
// 2-entry FIFO. Reads are throttled so FIFO entries plus the in-flight read
// never exceed two, which keeps one beat per cycle when the sink is ready.
module bram_stream_reader #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              abort,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W:0]   len,
    output logic              busy,
    output logic              done,
    output logic              ram_en,
    output logic              ram_we,
    output logic              ram_rst,
    output logic [ADDR_W-1:0] ram_addr,
    input  logic [DATA_W-1:0] ram_dout,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [DATA_W-1:0] m_data,
    output logic              m_last
);
    typedef enum logic [1:0] {IDLE, READ, DRAIN, DONE} state_t;

    localparam logic [ADDR_W:0]   ONE_L = (ADDR_W+1)'(1);
    localparam logic [ADDR_W-1:0] ONE_A = ADDR_W'(1);

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [ADDR_W:0]     len_q, len_d;
    logic [ADDR_W:0]     rd_cnt_q, rd_cnt_d;
    logic [ADDR_W:0]     out_cnt_q, out_cnt_d;
    logic                pend_q, pend_d;
    logic [DATA_W-1:0]   ent0_q, ent0_d;
    logic [DATA_W-1:0]   ent1_q, ent1_d;
    logic                wr_ptr_q, wr_ptr_d;
    logic                rd_ptr_q, rd_ptr_d;
    logic [1:0]          cnt_q, cnt_d;

    logic                fifo_valid;
    logic                pop;
    logic                push;
    logic                flush;
    logic                issue;
    logic                last_beat;
    logic [2:0]          occ;

    // Next-state, read issue and FIFO bookkeeping.
    always_comb begin
        fifo_valid = (cnt_q != 2'd0);
        pop        = fifo_valid && m_ready;
        push       = pend_q;
        flush      = abort && ((state_q == READ) || (state_q == DRAIN));
        // Occupancy after this cycle's pop, counting the read already on ram_dout.
        occ        = {1'b0, cnt_q} + {2'b00, pend_q} - {2'b00, pop};
        issue      = (state_q == READ) && !abort && (rd_cnt_q != len_q) && (occ < 3'd2);
        last_beat  = fifo_valid && (out_cnt_q == len_q - ONE_L);

        state_d   = state_q;
        addr_d    = addr_q;
        len_d     = len_q;
        rd_cnt_d  = rd_cnt_q;
        out_cnt_d = pop ? out_cnt_q + ONE_L : out_cnt_q;
        pend_d    = issue;
        ent0_d    = ent0_q;
        ent1_d    = ent1_q;
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        cnt_d     = cnt_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    addr_d    = base_addr;
                    len_d     = len;
                    rd_cnt_d  = '0;
                    out_cnt_d = '0;
                    state_d   = (len == '0) ? DONE : READ;
                end
            end
            READ: begin
                if (flush) begin
                    state_d = IDLE;
                end else if (issue) begin
                    addr_d   = addr_q + ONE_A;
                    rd_cnt_d = rd_cnt_q + ONE_L;
                    if (rd_cnt_q + ONE_L == len_q) begin
                        state_d = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if (flush) begin
                    state_d = IDLE;
                end else if (pop && last_beat) begin
                    state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        if (flush) begin
            pend_d   = 1'b0;
            wr_ptr_d = 1'b0;
            rd_ptr_d = 1'b0;
            cnt_d    = 2'd0;
        end else begin
            if (push) begin
                if (wr_ptr_q) begin
                    ent1_d = ram_dout;
                end else begin
                    ent0_d = ram_dout;
                end
                wr_ptr_d = ~wr_ptr_q;
            end
            if (pop) begin
                rd_ptr_d = ~rd_ptr_q;
            end
            cnt_d = cnt_q + {1'b0, push} - {1'b0, pop};
        end
    end

    // State, counters and FIFO storage.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            addr_q    <= '0;
            len_q     <= '0;
            rd_cnt_q  <= '0;
            out_cnt_q <= '0;
            pend_q    <= 1'b0;
            ent0_q    <= '0;
            ent1_q    <= '0;
            wr_ptr_q  <= 1'b0;
            rd_ptr_q  <= 1'b0;
            cnt_q     <= 2'd0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            len_q     <= len_d;
            rd_cnt_q  <= rd_cnt_d;
            out_cnt_q <= out_cnt_d;
            pend_q    <= pend_d;
            ent0_q    <= ent0_d;
            ent1_q    <= ent1_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            cnt_q     <= cnt_d;
        end
    end

    assign busy     = (state_q == READ) || (state_q == DRAIN);
    assign done     = (state_q == DONE);
    assign ram_en   = issue;
    assign ram_we   = 1'b0;
    assign ram_rst  = 1'b0;
    assign ram_addr = addr_q;
    assign m_valid  = fifo_valid;
    assign m_data   = rd_ptr_q ? ent1_q : ent0_q;
    assign m_last   = last_beat;

endmodule

// File: tb/tb_bram_stream_reader.sv
// tb_bram_stream_reader: drives bursts into bram_stream_reader with a
// behavioural block RAM and compares the stream against a list model.
module tb_bram_stream_reader;
    localparam int AW    = 10;
    localparam int DW    = 16;
    localparam int DEPTH = 1 << AW;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic          abort = 1'b0;
    logic [AW-1:0] base_addr = '0;
    logic [AW:0]   len = '0;
    logic          busy, done, ram_en, ram_we, ram_rst;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_dout = '0;
    logic          m_valid;
    logic          m_ready = 1'b0;
    logic [DW-1:0] m_data;
    logic          m_last;

    logic [DW-1:0] mem [0:DEPTH-1];

    int n_cmp = 0;
    int n_err = 0;

    // burst observations
    logic [DW-1:0] beats[$];
    bit            lasts[$];
    int            addrs[$];
    int en_cnt, done_cnt, busy_cnt, valid_cnt, first_valid, last_beat_cyc, done_cyc;
    int stab_err, occ_err, post_abort_err;
    bit timeout;

    // reference model output
    logic [DW-1:0] exp_q[$];
    int            exp_a[$];

    bram_stream_reader #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
        .base_addr(base_addr), .len(len), .busy(busy), .done(done),
        .ram_en(ram_en), .ram_we(ram_we), .ram_rst(ram_rst), .ram_addr(ram_addr),
        .ram_dout(ram_dout), .m_valid(m_valid), .m_ready(m_ready),
        .m_data(m_data), .m_last(m_last)
    );

    always #5 clk = ~clk;

    // Block RAM with one cycle of read latency.
    always @(posedge clk) if (ram_en) ram_dout <= mem[ram_addr];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    function automatic void load_linear();
        for (int i = 0; i < DEPTH; i++) mem[i] = DW'(i);
    endfunction

    function automatic void load_random();
        for (int i = 0; i < DEPTH; i++) mem[i] = DW'($urandom);
    endfunction

    function automatic void build_exp(int b, int l);
        exp_q.delete();
        exp_a.delete();
        for (int i = 0; i < l; i++) begin
            exp_a.push_back((b + i) % DEPTH);
            exp_q.push_back(mem[(b + i) % DEPTH]);
        end
    endfunction

    function automatic logic pick(int mode);
        if (mode == 0) return 1'b1;
        if (mode == 2) return 1'b0;
        return 1'($urandom_range(0, 1));
    endfunction

    function automatic int data_errs();
        int e = 0;
        for (int i = 0; i < exp_q.size(); i++)
            if (i >= beats.size() || beats[i] !== exp_q[i]) e++;
        return e;
    endfunction

    function automatic int last_errs(int l);
        int e = 0;
        for (int i = 0; i < lasts.size(); i++)
            if (lasts[i] != (i == l - 1)) e++;
        return e;
    endfunction

    function automatic int addr_errs();
        int e = 0;
        for (int i = 0; i < exp_a.size(); i++)
            if (i >= addrs.size() || addrs[i] != exp_a[i]) e++;
        return e;
    endfunction

    // Runs one burst; cycle 0 is the cycle in which start is presented.
    task automatic run_burst(input int b, input int l, input int ready_mode,
                             input int abort_after, input bit start_noise);
        int outstanding, abort_cyc, budget;
        bit fin, prev_stall;
        logic [DW-1:0] prev_data;
        beats.delete(); lasts.delete(); addrs.delete();
        en_cnt = 0; done_cnt = 0; busy_cnt = 0; valid_cnt = 0;
        first_valid = -1; last_beat_cyc = -1; done_cyc = -1;
        stab_err = 0; occ_err = 0; post_abort_err = 0; timeout = 0;
        outstanding = 0; abort_cyc = -1; fin = 0; prev_stall = 0; prev_data = '0;
        budget = l * 8 + 60;
        @(posedge clk); #1;
        start = 1'b1; base_addr = AW'(b); len = (AW+1)'(l); abort = 1'b0;
        m_ready = pick(ready_mode);
        for (int cyc = 0; cyc < budget && !fin; cyc++) begin
            @(negedge clk);
            if (ram_en) begin en_cnt++; addrs.push_back(int'(ram_addr)); outstanding++; end
            if (done) begin done_cnt++; if (done_cyc < 0) done_cyc = cyc; end
            if (busy) busy_cnt++;
            if (m_valid) begin valid_cnt++; if (first_valid < 0) first_valid = cyc; end
            if (prev_stall && abort_cyc < 0 && (m_valid !== 1'b1 || m_data !== prev_data)) stab_err++;
            if (m_valid && m_ready) begin
                beats.push_back(m_data); lasts.push_back(m_last);
                last_beat_cyc = cyc; outstanding--;
            end
            if (outstanding > 2) occ_err++;
            if (abort_cyc >= 0 && cyc > abort_cyc && (m_valid || ram_en || busy || done)) post_abort_err++;
            prev_stall = m_valid && !m_ready;
            prev_data  = m_data;
            if (done_cyc >= 0 || (abort_cyc >= 0 && cyc >= abort_cyc + 4)) fin = 1;
            @(posedge clk); #1;
            start   = start_noise ? 1'($urandom_range(0, 1)) : 1'b0;
            abort   = 1'b0;
            m_ready = pick(ready_mode);
            if (abort_after >= 0 && abort_cyc < 0 && beats.size() == abort_after) begin
                abort = 1'b1; m_ready = 1'b0; abort_cyc = cyc + 1;
            end
        end
        start = 1'b0; abort = 1'b0;
        if (!fin) timeout = 1;
    endtask

    task automatic test_reset();
        #3;
        n_cmp++; if (busy !== 1'b0)     begin n_err++; $display("FAIL reset_busy: got %b expected 0", busy); end
        n_cmp++; if (done !== 1'b0)     begin n_err++; $display("FAIL reset_done: got %b expected 0", done); end
        n_cmp++; if (ram_en !== 1'b0)   begin n_err++; $display("FAIL reset_ram_en: got %b expected 0", ram_en); end
        n_cmp++; if (ram_addr !== '0)   begin n_err++; $display("FAIL reset_ram_addr: got %0d expected 0", ram_addr); end
        n_cmp++; if (m_valid !== 1'b0)  begin n_err++; $display("FAIL reset_m_valid: got %b expected 0", m_valid); end
        n_cmp++; if (m_last !== 1'b0)   begin n_err++; $display("FAIL reset_m_last: got %b expected 0", m_last); end
        n_cmp++; if (m_data !== '0)     begin n_err++; $display("FAIL reset_m_data: got %0d expected 0", m_data); end
        n_cmp++; if ({ram_we, ram_rst} !== 2'b00) begin n_err++; $display("FAIL reset_we_rst: got %b expected 00", {ram_we, ram_rst}); end
        #19;
        rst_n = 1'b1;
    endtask

    task automatic test_basic();
        load_linear();
        run_burst(5, 4, 0, -1, 0);
        build_exp(5, 4);
        n_cmp++; if (timeout)              begin n_err++; $display("FAIL basic_timeout: burst did not complete"); end
        n_cmp++; if (beats.size() != 4)    begin n_err++; $display("FAIL basic_count: got %0d expected 4", beats.size()); end
        n_cmp++; if (data_errs() != 0)     begin n_err++; $display("FAIL basic_data: %0d wrong beats expected 0", data_errs()); end
        n_cmp++; if (last_errs(4) != 0)    begin n_err++; $display("FAIL basic_last: %0d wrong m_last expected 0", last_errs(4)); end
        n_cmp++; if (en_cnt != 4)          begin n_err++; $display("FAIL basic_ram_en: got %0d expected 4", en_cnt); end
        n_cmp++; if (done_cnt != 1)        begin n_err++; $display("FAIL basic_done_cnt: got %0d expected 1", done_cnt); end
        n_cmp++; if (done_cyc != last_beat_cyc + 1) begin n_err++; $display("FAIL basic_done_time: got %0d expected %0d", done_cyc, last_beat_cyc + 1); end
        n_cmp++; if (first_valid != 3)     begin n_err++; $display("FAIL basic_first_valid: got %0d expected 3", first_valid); end
        n_cmp++; if (busy_cnt != 6)        begin n_err++; $display("FAIL basic_busy_cycles: got %0d expected 6", busy_cnt); end
    endtask

    task automatic test_wrap();
        load_linear();
        run_burst(1022, 4, 0, -1, 0);
        build_exp(1022, 4);
        n_cmp++; if (timeout)           begin n_err++; $display("FAIL wrap_timeout: burst did not complete"); end
        n_cmp++; if (addr_errs() != 0)  begin n_err++; $display("FAIL wrap_addr: %0d wrong addresses expected 0", addr_errs()); end
        n_cmp++; if (data_errs() != 0 || beats.size() != 4) begin n_err++; $display("FAIL wrap_data: %0d wrong of %0d beats expected 0 of 4", data_errs(), beats.size()); end
    endtask

    task automatic test_stall();
        load_linear();
        run_burst(100, 8, 1, -1, 1);
        build_exp(100, 8);
        n_cmp++; if (timeout)           begin n_err++; $display("FAIL stall_timeout: burst did not complete"); end
        n_cmp++; if (beats.size() != 8 || data_errs() != 0) begin n_err++; $display("FAIL stall_data: %0d wrong of %0d beats expected 0 of 8", data_errs(), beats.size()); end
        n_cmp++; if (stab_err != 0)     begin n_err++; $display("FAIL stall_stable: got %0d unstable cycles expected 0", stab_err); end
        n_cmp++; if (occ_err != 0)      begin n_err++; $display("FAIL stall_occupancy: got %0d overfull cycles expected 0", occ_err); end
        n_cmp++; if (en_cnt != 8)       begin n_err++; $display("FAIL stall_ram_en: got %0d expected 8", en_cnt); end
        n_cmp++; if (done_cnt != 1)     begin n_err++; $display("FAIL stall_done_cnt: got %0d expected 1", done_cnt); end
    endtask

    task automatic test_len0();
        run_burst(37, 0, 0, -1, 0);
        n_cmp++; if (timeout)           begin n_err++; $display("FAIL len0_timeout: no done seen"); end
        n_cmp++; if (en_cnt != 0)       begin n_err++; $display("FAIL len0_ram_en: got %0d expected 0", en_cnt); end
        n_cmp++; if (valid_cnt != 0)    begin n_err++; $display("FAIL len0_valid: got %0d expected 0", valid_cnt); end
        n_cmp++; if (done_cnt != 1)     begin n_err++; $display("FAIL len0_done_cnt: got %0d expected 1", done_cnt); end
        n_cmp++; if (busy_cnt != 0)     begin n_err++; $display("FAIL len0_busy: got %0d expected 0", busy_cnt); end
    endtask

    task automatic test_abort();
        load_linear();
        run_burst(200, 16, 0, 5, 0);
        build_exp(200, 5);
        n_cmp++; if (timeout)             begin n_err++; $display("FAIL abort_timeout: abort window not reached"); end
        n_cmp++; if (beats.size() != 5 || data_errs() != 0) begin n_err++; $display("FAIL abort_beats: %0d wrong of %0d beats expected 0 of 5", data_errs(), beats.size()); end
        n_cmp++; if (post_abort_err != 0) begin n_err++; $display("FAIL abort_quiet: got %0d active cycles expected 0", post_abort_err); end
        n_cmp++; if (done_cnt != 0)       begin n_err++; $display("FAIL abort_done: got %0d expected 0", done_cnt); end
        run_burst(0, 2, 0, -1, 0);
        build_exp(0, 2);
        n_cmp++; if (beats.size() != 2 || data_errs() != 0) begin n_err++; $display("FAIL abort_restart: %0d wrong of %0d beats expected 0 of 2", data_errs(), beats.size()); end
        n_cmp++; if (last_errs(2) != 0 || done_cnt != 1) begin n_err++; $display("FAIL abort_restart_end: last errs %0d done %0d expected 0 and 1", last_errs(2), done_cnt); end
    endtask

    task automatic test_reset_mid();
        int bad;
        load_linear();
        @(posedge clk); #1;
        start = 1'b1; base_addr = AW'(300); len = (AW+1)'(10); m_ready = 1'b0;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (5) @(posedge clk);
        @(negedge clk);
        n_cmp++; if (m_valid !== 1'b1 || busy !== 1'b1) begin n_err++; $display("FAIL rstmid_pre: valid %b busy %b expected 1 1", m_valid, busy); end
        #2 rst_n = 1'b0;
        #1;
        n_cmp++; if ({busy, done, ram_en, m_valid, m_last} !== 5'b0) begin n_err++; $display("FAIL rstmid_flags: got %b expected 00000", {busy, done, ram_en, m_valid, m_last}); end
        n_cmp++; if (ram_addr !== '0 || m_data !== '0) begin n_err++; $display("FAIL rstmid_buses: addr %0d data %0d expected 0 0", ram_addr, m_data); end
        @(negedge clk); #2;
        rst_n = 1'b1;
        m_ready = 1'b1;
        bad = 0;
        repeat (8) begin
            @(negedge clk);
            if (m_valid || done || busy || ram_en) bad++;
        end
        n_cmp++; if (bad != 0) begin n_err++; $display("FAIL rstmid_quiet: got %0d active cycles expected 0", bad); end
        run_burst(700, 1, 0, -1, 0);
        build_exp(700, 1);
        n_cmp++; if (beats.size() != 1 || data_errs() != 0) begin n_err++; $display("FAIL rstmid_single: %0d wrong of %0d beats expected 0 of 1", data_errs(), beats.size()); end
        n_cmp++; if (((lasts.size() > 0) ? lasts[0] : 1'b0) != 1'b1) begin n_err++; $display("FAIL rstmid_last: got %0d expected 1", (lasts.size() > 0) ? lasts[0] : 1'b0); end
    endtask

    task automatic test_full_len();
        int b;
        load_random();
        b = $urandom_range(0, DEPTH - 1);
        run_burst(b, DEPTH, 0, -1, 0);
        build_exp(b, DEPTH);
        n_cmp++; if (beats.size() != DEPTH || data_errs() != 0) begin n_err++; $display("FAIL full_data: %0d wrong of %0d beats expected 0 of %0d", data_errs(), beats.size(), DEPTH); end
        n_cmp++; if (last_errs(DEPTH) != 0) begin n_err++; $display("FAIL full_last: got %0d wrong expected 0", last_errs(DEPTH)); end
        n_cmp++; if (busy_cnt != DEPTH + 2) begin n_err++; $display("FAIL full_busy: got %0d expected %0d", busy_cnt, DEPTH + 2); end
    endtask

    task automatic test_random();
        int b, l;
        for (int n = 0; n < 6; n++) begin
            load_random();
            b = $urandom_range(0, DEPTH - 1);
            l = $urandom_range(1, 40);
            run_burst(b, l, 1, -1, 1);
            build_exp(b, l);
            n_cmp++; if (timeout) begin n_err++; $display("FAIL rand%0d_timeout: base %0d len %0d", n, b, l); end
            n_cmp++; if (beats.size() != l || data_errs() != 0) begin n_err++; $display("FAIL rand%0d_data: %0d wrong of %0d beats expected 0 of %0d", n, data_errs(), beats.size(), l); end
            n_cmp++; if (last_errs(l) != 0) begin n_err++; $display("FAIL rand%0d_last: got %0d wrong expected 0", n, last_errs(l)); end
            n_cmp++; if (addr_errs() != 0 || en_cnt != l) begin n_err++; $display("FAIL rand%0d_reads: %0d wrong addr, %0d reads expected 0, %0d", n, addr_errs(), en_cnt, l); end
            n_cmp++; if (stab_err != 0 || occ_err != 0) begin n_err++; $display("FAIL rand%0d_flow: stab %0d occ %0d expected 0 0", n, stab_err, occ_err); end
            n_cmp++; if (done_cnt != 1 || done_cyc != last_beat_cyc + 1) begin n_err++; $display("FAIL rand%0d_done: cnt %0d at %0d expected 1 at %0d", n, done_cnt, done_cyc, last_beat_cyc + 1); end
        end
    endtask

    initial begin
        load_linear();
        test_reset();
        test_basic();
        test_wrap();
        test_stall();
        test_len0();
        test_abort();
        test_reset_mid();
        test_full_len();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/bram_stream_reader.md
BRAM_STREAM_READER -- requirements
Module: bram_stream_reader

Interface
REQ-001 SHALL have parameter ADDR_W, default 10, RAM address width.
REQ-002 SHALL have parameter DATA_W, default 16, RAM/stream data width.
REQ-003 SHALL have port clk  input  1  single clock; all logic on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port start  input  1  request a burst read; sampled only in IDLE.
REQ-006 SHALL have port abort  input  1  synchronous cancel of the current burst.
REQ-007 SHALL have port base_addr  input  ADDR_W  first word address, captured on accepted start.
REQ-008 SHALL have port len  input  ADDR_W+1  word count 0..2^ADDR_W, captured on accepted start.
REQ-009 SHALL have port busy  output  1  high from the cycle after accepted start until done.
REQ-010 SHALL have port done  output  1  one-cycle completion pulse.
REQ-011 SHALL have port ram_en  output  1  RAM enable; read issued when high.
REQ-012 SHALL have port ram_we  output  1  RAM write enable, constant 0.
REQ-013 SHALL have port ram_rst  output  1  RAM output reset, constant 0.
REQ-014 SHALL have port ram_addr  output  ADDR_W  RAM address.
REQ-015 SHALL have port ram_dout  input  DATA_W  RAM read data, valid exactly 1 cycle after ram_en.
REQ-016 SHALL have port m_valid / m_ready / m_data[DATA_W] / m_last  out/in/out/out  stream output.

Function
REQ-017 SHALL implement FSM states IDLE, READ, DRAIN, DONE.
REQ-018 IDLE: start=1 with len>0 SHALL capture base_addr/len, go to READ; start with len=0 SHALL go to DONE directly with no RAM access and no beats.
REQ-019 start outside IDLE SHALL be ignored.
REQ-020 READ: read i (0..len-1) SHALL use ram_addr = (base_addr + i) mod 2^ADDR_W; wrap past top address is legal.
REQ-021 Read data SHALL be captured from ram_dout one cycle after its ram_en into a 2-entry FIFO feeding m_data.
REQ-022 A read SHALL be issued in a cycle only if (FIFO entries + in-flight read - pop this cycle) < 2; the FIFO SHALL never overflow and no read SHALL be lost or duplicated.
REQ-023 With m_ready held high, m_valid SHALL first rise 2 cycles after READ entry and sustain one beat per cycle.
REQ-024 A beat transfers when m_valid & m_ready; m_valid/m_data SHALL be stable while m_valid & !m_ready.
REQ-025 m_last SHALL be high exactly on beat len-1.
REQ-026 After the last read is issued, FSM SHALL go to DRAIN; DRAIN -> DONE on the transfer of the m_last beat.
REQ-027 DONE SHALL last 1 cycle with done=1, busy=0, then IDLE; busy SHALL be high in READ and DRAIN only.
REQ-028 abort in READ/DRAIN SHALL, next cycle: flush FIFO, discard any in-flight return, m_valid=0, ram_en=0, go to IDLE; done SHALL NOT pulse; abort in IDLE/DONE has no effect.
REQ-029 ram_en SHALL be 0 in IDLE, DONE, DRAIN.

Reset
REQ-030 rst_n=0 SHALL immediately force IDLE, FIFO empty, busy=0, done=0, ram_en=0, ram_addr=0, m_valid=0, m_last=0, m_data=0.
REQ-031 Reset mid-burst SHALL discard all pending data; no beat or done SHALL appear after rst_n rises until a new start.

Verification
REQ-032 RAM preloaded ram[i]=i; start base=5,len=4, m_ready=1 -> beats 5,6,7,8, m_last on 8, done 1 cycle after last beat, 4 ram_en cycles.
REQ-033 base=1022,len=4 -> addresses 1022,1023,0,1; data order matches.
REQ-034 len=8, m_ready toggling 1/0 random -> all 8 beats in order, data stable during stalls, never >2 buffered, ram_en count = 8.
REQ-035 len=0 -> no ram_en, no m_valid, done pulses once, busy never high.
REQ-036 len=16, abort after 5 beats -> m_valid low next cycle, no done; new start base=0,len=2 -> beats 0,1 only.
REQ-037 rst_n low mid-burst with m_ready=0 -> all outputs zero immediately; subsequent start len=1 -> single beat with m_last=1.
